// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================
// Module  : mem_arb_pkg
// Brief   : shared state and requester encodings for the cache/SDRAM arbiter
// Revision: 1.0
// ============================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_PROG = 1'b0,
        SRC_DATA = 1'b1
    } req_src_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================
// Module  : cache_mem_arbiter_if
// Brief   : cache-side and SDRAM-side signals of the arbiter; slave = arbiter view
// Revision: 1.0
// ============================================================
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              p_rd_req;
    logic [ADDR_W-1:0] p_addr;
    logic              p_rvalid;
    logic              p_done;
    logic              d_rd_req;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_wnext;
    logic              d_rvalid;
    logic              d_done;
    logic [DATA_W-1:0] rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wnext;
    logic              busy;

    modport slave (
        input  p_rd_req, p_addr, d_rd_req, d_wr_req, d_addr, d_wdata,
               mem_ack, mem_rvalid, mem_rdata, mem_wnext,
        output p_rvalid, p_done, d_wnext, d_rvalid, d_done, rdata,
               mem_req, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output p_rd_req, p_addr, d_rd_req, d_wr_req, d_addr, d_wdata,
               mem_ack, mem_rvalid, mem_rdata, mem_wnext,
        input  p_rvalid, p_done, d_wnext, d_rvalid, d_done, rdata,
               mem_req, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================
// Module  : rr_arbiter2
// Brief   : two-way round-robin picker; the side not granted last wins a tie
// Revision: 1.0
// ============================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic req_p,
    input  wire logic req_d,
    input  wire logic grant_en,
    output req_src_t  grant
);

    req_src_t r_rr_last;

    always_comb begin
        grant = SRC_PROG;
        if (req_p && req_d) begin
            grant = (r_rr_last == SRC_PROG) ? SRC_DATA : SRC_PROG;
        end else if (req_d) begin
            grant = SRC_DATA;
        end
    end

    // Resetting to PROG hands the first contention to the data side.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= SRC_PROG;
        end else if (grant_en && (req_p || req_d)) begin
            r_rr_last <= grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================
// Module  : cache_mem_arbiter
// Brief   : shares one SDRAM controller port between program and data caches
// Revision: 1.0
// ============================================================
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cache_mem_arbiter_if.slave  bus
);

    localparam int C_BEAT_CNT_W = $clog2(BURST_LEN);
    localparam logic [C_BEAT_CNT_W-1:0] C_LAST_BEAT = C_BEAT_CNT_W'(BURST_LEN - 1);

    arb_state_t              r_state;
    req_src_t                r_src;
    logic                    r_wr;
    logic                    r_mem_req;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic                    r_p_done;
    logic                    r_d_done;
    logic                    r_busy;
    logic [C_BEAT_CNT_W-1:0] r_beat_cnt;

    req_src_t w_pick;
    logic     w_any_req;
    logic     w_window;
    logic     w_rd_beat;
    logic     w_wr_beat;
    logic     w_beat;
    logic     w_last;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_p    (bus.p_rd_req),
        .req_d    (bus.d_rd_req | bus.d_wr_req),
        .grant_en (r_state == IDLE),
        .grant    (w_pick)
    );

    assign w_any_req = bus.p_rd_req | bus.d_rd_req | bus.d_wr_req;
    // The controller may return the first beat in the same cycle it acks.
    assign w_window  = (r_state == XFER) || ((r_state == REQ) && bus.mem_ack);
    assign w_rd_beat = w_window && !r_wr && bus.mem_rvalid;
    assign w_wr_beat = w_window &&  r_wr && bus.mem_wnext;
    assign w_beat    = w_rd_beat || w_wr_beat;
    assign w_last    = w_beat && (r_beat_cnt == C_LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_src      <= SRC_PROG;
            r_wr       <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_p_done   <= 1'b0;
            r_d_done   <= 1'b0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_p_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_src      <= w_pick;
                        r_wr       <= (w_pick == SRC_DATA) && bus.d_wr_req;
                        r_mem_addr <= (w_pick == SRC_PROG) ? bus.p_addr : bus.d_addr;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= XFER;
                    end
                end
                XFER: begin
                    if (w_last) begin
                        r_p_done <= (r_src == SRC_PROG);
                        r_d_done <= (r_src == SRC_DATA);
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_beat) begin
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_wr    = r_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.p_rvalid  = w_rd_beat && (r_src == SRC_PROG);
    assign bus.d_rvalid  = w_rd_beat && (r_src == SRC_DATA);
    assign bus.d_wnext   = w_wr_beat;
    assign bus.p_done    = r_p_done;
    assign bus.d_done    = r_d_done;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================
// Module  : tb_cache_mem_arbiter
// Brief   : scoreboard bench for cache_mem_arbiter with a scripted SDRAM model
// Revision: 1.0
// ============================================================
module tb_cache_mem_arbiter;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic              to_data;
        logic              wr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // One complete granted transfer: command check, ack, BURST_LEN beats, done, idle.
    task automatic serve(input logic src_d, input logic wr, input logic [ADDR_W-1:0] addr,
                         input int ack_delay, input logic beat_with_ack,
                         input logic stray_in_done, input logic [DATA_W-1:0] base,
                         input string name);
        int   waited;
        exp_t e;
        waited = 0;
        while (bus.mem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (bus.mem_req !== 1'b1 || waited != 1) begin
            n_fail++;
            $display("FAIL %s req_latency: mem_req=%b after %0d cycles, required 1 after 1", name, bus.mem_req, waited);
            if (bus.mem_req !== 1'b1) return;
        end
        for (int i = 0; i <= ack_delay; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if (bus.mem_req !== 1'b1 || bus.mem_wr !== wr || bus.mem_addr !== addr || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s cmd: req=%b wr=%b addr=%h busy=%b, required 1 %b %h 1",
                         name, bus.mem_req, bus.mem_wr, bus.mem_addr, bus.busy, wr, addr);
            end
        end
        bus.mem_ack = 1'b1;
        if (!beat_with_ack) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        for (int i = 0; i < BURST_LEN; i++) begin
            e.to_data = src_d;
            e.wr      = wr;
            e.data    = base + DATA_W'(i);
            if (wr) begin
                bus.d_wdata   = e.data;
                bus.mem_wnext = 1'b1;
            end else begin
                bus.mem_rdata  = e.data;
                bus.mem_rvalid = 1'b1;
            end
            sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            n_tests++;
            if (e.wr) begin
                if (bus.d_wnext !== 1'b1 || bus.mem_wdata !== e.data || bus.p_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s wr_beat%0d: d_wnext=%b mem_wdata=%h rvalid(p,d)=%b%b, required 1 %h 00",
                             name, i, bus.d_wnext, bus.mem_wdata, bus.p_rvalid, bus.d_rvalid, e.data);
                end
            end else begin
                if (bus.p_rvalid !== !e.to_data || bus.d_rvalid !== e.to_data || bus.rdata !== e.data || bus.d_wnext !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s rd_beat%0d: p_rvalid=%b d_rvalid=%b rdata=%h d_wnext=%b, required %b %b %h 0",
                             name, i, bus.p_rvalid, bus.d_rvalid, bus.rdata, bus.d_wnext, !e.to_data, e.to_data, e.data);
                end
            end
            n_tests++;
            if (bus.p_done !== 1'b0 || bus.d_done !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s mid_burst%0d: p_done=%b d_done=%b busy=%b, required 0 0 1",
                         name, i, bus.p_done, bus.d_done, bus.busy);
            end
            @(negedge clk);
            bus.mem_ack    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_wnext  = 1'b0;
        end
        if (stray_in_done) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 16'hDEAD;
        end
        #1;
        n_tests++;
        if (bus.p_done !== !src_d || bus.d_done !== src_d || bus.busy !== 1'b1 ||
            bus.p_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: p_done=%b d_done=%b busy=%b rvalid(p,d)=%b%b, required %b %b 1 00",
                     name, bus.p_done, bus.d_done, bus.busy, bus.p_rvalid, bus.d_rvalid, !src_d, src_d);
        end
        if (!src_d)  bus.p_rd_req = 1'b0;
        else if (wr) bus.d_wr_req = 1'b0;
        else         bus.d_rd_req = 1'b0;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++;
        if (bus.p_done !== 1'b0 || bus.d_done !== 1'b0 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: p_done=%b d_done=%b busy=%b mem_req=%b, required 0 0 0 0",
                     name, bus.p_done, bus.d_done, bus.busy, bus.mem_req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_addr !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cmd: req=%b wr=%b addr=%h busy=%b, required 0 0 000000 0",
                     bus.mem_req, bus.mem_wr, bus.mem_addr, bus.busy);
        end
        n_tests++;
        if (bus.p_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.p_done !== 1'b0 ||
            bus.d_done !== 1'b0 || bus.d_wnext !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: p_rvalid=%b d_rvalid=%b p_done=%b d_done=%b d_wnext=%b, required all 0",
                     bus.p_rvalid, bus.d_rvalid, bus.p_done, bus.d_done, bus.d_wnext);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_prog();
        bus.p_addr   = 24'h001230;
        bus.p_rd_req = 1'b1;
        serve(1'b0, 1'b0, 24'h001230, 1, 1'b0, 1'b0, 16'hA000, "prog_fill");
    endtask

    task automatic test_contention();
        bus.p_addr   = 24'h000100;
        bus.d_addr   = 24'h000200;
        bus.p_rd_req = 1'b1;
        bus.d_rd_req = 1'b1;
        serve(1'b1, 1'b0, 24'h000200, 0, 1'b0, 1'b0, 16'hB000, "rr_d1");
        serve(1'b0, 1'b0, 24'h000100, 0, 1'b0, 1'b0, 16'hB100, "rr_p1");
        bus.p_rd_req = 1'b1;
        bus.d_rd_req = 1'b1;
        serve(1'b1, 1'b0, 24'h000200, 0, 1'b0, 1'b0, 16'hB200, "rr_d2");
        bus.d_rd_req = 1'b1;
        serve(1'b0, 1'b0, 24'h000100, 0, 1'b0, 1'b0, 16'hB300, "rr_p2");
        serve(1'b1, 1'b0, 24'h000200, 0, 1'b0, 1'b0, 16'hB400, "rr_d3");
    endtask

    task automatic test_writeback();
        bus.d_addr   = 24'h00F000;
        bus.d_wr_req = 1'b1;
        bus.d_rd_req = 1'b1;
        serve(1'b1, 1'b1, 24'h00F000, 1, 1'b0, 1'b0, 16'hC000, "wb_write");
        serve(1'b1, 1'b0, 24'h00F000, 0, 1'b0, 1'b0, 16'hD000, "wb_refill");
    endtask

    task automatic test_beat_with_ack();
        bus.d_addr   = 24'h003450;
        bus.d_rd_req = 1'b1;
        serve(1'b1, 1'b0, 24'h003450, 0, 1'b1, 1'b0, 16'hE000, "ack_beat");
    endtask

    task automatic test_reset_mid_burst();
        int waited;
        waited       = 0;
        bus.p_addr   = 24'h777000;
        bus.p_rd_req = 1'b1;
        while (bus.mem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 16'h5000 + 16'(i);
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.p_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: mem_req=%b busy=%b p_done=%b, required 0 0 0", bus.mem_req, bus.busy, bus.p_done);
        end
        @(negedge clk);
        n_tests++;
        if (bus.p_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold: p_done=%b busy=%b, required 0 0", bus.p_done, bus.busy);
        end
        reset        = 1'b0;
        bus.d_addr   = 24'h000880;
        bus.d_rd_req = 1'b1;
        serve(1'b1, 1'b0, 24'h000880, 0, 1'b0, 1'b0, 16'h6000, "post_reset_d");
        serve(1'b0, 1'b0, 24'h777000, 0, 1'b0, 1'b0, 16'h6100, "post_reset_p");
    endtask

    task automatic test_stray_beats();
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_wnext  = 1'b1;
            bus.mem_rdata  = 16'hBAD0 + 16'(i);
            #1;
            n_tests++;
            if (bus.p_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.d_wnext !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_idle%0d: p_rvalid=%b d_rvalid=%b d_wnext=%b busy=%b, required 0 0 0 0",
                         i, bus.p_rvalid, bus.d_rvalid, bus.d_wnext, bus.busy);
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_wnext  = 1'b0;
        bus.d_addr     = 24'h000040;
        bus.d_rd_req   = 1'b1;
        serve(1'b1, 1'b0, 24'h000040, 0, 1'b0, 1'b1, 16'h7000, "stray_d");
        bus.p_addr   = 24'h000080;
        bus.p_rd_req = 1'b1;
        serve(1'b0, 1'b0, 24'h000080, 0, 1'b0, 1'b0, 16'h7100, "stray_p");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.p_rd_req   = 1'b0;
        bus.p_addr     = '0;
        bus.d_rd_req   = 1'b0;
        bus.d_wr_req   = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_wnext  = 1'b0;
        test_reset();
        test_single_prog();
        test_contention();
        test_writeback();
        test_beat_with_ack();
        test_reset_mid_burst();
        test_stray_beats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
